// File: rtl/zap_game_engine.sv
// RoboZap rule engine: validates UART command words, applies zaps to the
// per-player switch table and lives, and returns one status byte per command.

module zap_player #(
    parameter int SW_W  = 3,
    parameter int LIVES = 3,
    parameter int LW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 zap,
    input  logic [SW_W-1:0]      sw,
    output logic [2**SW_W-1:0]   row,
    output logic [LW-1:0]        lives
);
    // A kill ends the game, so lives is never decremented below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row   <= '1;
            lives <= LW'(LIVES);
        end else if (zap && row[sw]) begin
            row[sw] <= 1'b0;
            if (lives != '0) lives <= lives - LW'(1);
        end
    end
endmodule

module zap_game_engine #(
    parameter int TURN_W    = 3,
    parameter int SW_W      = 3,
    parameter int TGT_W     = 1,
    parameter int N_PLAYERS = 2,
    parameter int LIVES     = 3,
    localparam int CMD_W    = 1 + TURN_W + SW_W + TGT_W,
    localparam int LW       = $clog2(LIVES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CMD_W-1:0]              rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [N_PLAYERS*2**SW_W-1:0]  gtable_out,
    output logic [N_PLAYERS*LW-1:0]       lives_out,
    output logic                          game_over,
    output logic [TGT_W-1:0]              winner
);
    localparam int NSW = 2**SW_W;
    localparam logic [TGT_W:0]   NP   = (TGT_W+1)'(N_PLAYERS);
    localparam logic [TGT_W-1:0] LAST = TGT_W'(N_PLAYERS - 1);

    localparam logic [2:0] ST_MISS = 3'b000;
    localparam logic [2:0] ST_HIT  = 3'b001;
    localparam logic [2:0] ST_KILL = 3'b010;
    localparam logic [2:0] ST_PAR  = 3'b100;
    localparam logic [2:0] ST_TURN = 3'b101;
    localparam logic [2:0] ST_TGT  = 3'b110;
    localparam logic [2:0] ST_OVER = 3'b111;

    typedef enum logic [2:0] {IDLE, CHECK, APPLY, RESP, OVER} state_e;

    typedef struct packed {
        logic [TGT_W-1:0]  tgt;
        logic [SW_W-1:0]   sw;
        logic [TURN_W-1:0] turn;
        logic              par;
    } cmd_t;

    state_e state, state_nx;
    cmd_t   cmd_q;
    logic   err_q;
    logic [2:0] status_q;
    logic [TURN_W-1:0] exp_turn;
    logic [TGT_W-1:0]  shooter;

    logic [N_PLAYERS-1:0][NSW-1:0] gt;
    logic [N_PLAYERS-1:0][LW-1:0]  lv_arr;
    logic [N_PLAYERS-1:0]          zap;

    logic       chk_err;
    logic [2:0] chk_st;
    logic [NSW-1:0] tgt_row;
    logic [LW-1:0]  tgt_lv;
    logic [2:0]     ap_st;
    logic [LW-1:0]  ap_lv;
    logic           go_over;

    zap_player #(.SW_W(SW_W), .LIVES(LIVES), .LW(LW)) u_pl [N_PLAYERS-1:0] (
        .clk   (clk),
        .rst   (rst),
        .zap   (zap),
        .sw    (cmd_q.sw),
        .row   (gt),
        .lives (lv_arr)
    );

    assign gtable_out = gt;
    assign lives_out  = lv_arr;
    assign go_over    = game_over || (tx_data[7:5] == ST_KILL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_valid) state_nx = CHECK;
            CHECK:   state_nx = APPLY;
            APPLY:   state_nx = RESP;
            RESP:    if (tx_ready) state_nx = go_over ? OVER : IDLE;
            OVER:    if (rx_valid) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (state == IDLE) || (state == OVER);
        tx_valid = (state == RESP);
    end

    // Errors are checked in priority order: parity, turn, target.
    always_comb begin
        chk_err = 1'b1;
        chk_st  = ST_MISS;
        if (^cmd_q)                                         chk_st = ST_PAR;
        else if (cmd_q.turn != exp_turn)                    chk_st = ST_TURN;
        else if ({1'b0, cmd_q.tgt} >= NP || cmd_q.tgt == shooter) chk_st = ST_TGT;
        else                                                chk_err = 1'b0;
    end

    always_comb begin
        tgt_row = '0;
        tgt_lv  = '0;
        zap     = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (cmd_q.tgt == TGT_W'(p)) begin
                tgt_row = gt[p];
                tgt_lv  = lv_arr[p];
                zap[p]  = (state == APPLY) && !err_q;
            end
        end
    end

    always_comb begin
        ap_st = status_q;
        ap_lv = '0;
        if (!err_q) begin
            if (tgt_row[cmd_q.sw]) begin
                ap_lv = tgt_lv - LW'(1);
                ap_st = (ap_lv == '0) ? ST_KILL : ST_HIT;
            end else begin
                ap_lv = tgt_lv;
                ap_st = ST_MISS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= '0;
            err_q     <= 1'b0;
            status_q  <= '0;
            exp_turn  <= '0;
            shooter   <= '0;
            tx_data   <= '0;
            game_over <= 1'b0;
            winner    <= '0;
        end else begin
            case (state)
                IDLE: if (rx_valid) cmd_q <= rx_data;
                CHECK: begin
                    err_q    <= chk_err;
                    status_q <= chk_st;
                end
                APPLY: begin
                    tx_data <= {ap_st, 5'(ap_lv)};
                    if (!err_q) begin
                        exp_turn <= exp_turn + TURN_W'(1);
                        shooter  <= (shooter == LAST) ? '0 : shooter + TGT_W'(1);
                        if (ap_st == ST_KILL) winner <= shooter;
                    end
                end
                RESP: if (tx_ready && go_over) game_over <= 1'b1;
                OVER: if (rx_valid) tx_data <= {ST_OVER, 5'b0};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_zap_game_engine.sv
// Scoreboard bench for zap_game_engine at default parameters (2 players,
// 8 switches, 3 lives); expected bytes come from a behavioural game model.

module tb_zap_game_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] gtable_out;
    logic [3:0]  lives_out;
    logic        game_over;
    logic [0:0]  winner;

    zap_game_engine dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .gtable_out(gtable_out), .lives_out(lives_out),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [7:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // game model
    logic [15:0] m_gt;
    int m_lives[2];
    int m_turn, m_shooter, m_winner;
    bit m_over;

    function automatic void model_reset();
        m_gt = 16'hFFFF;
        m_lives[0] = 3; m_lives[1] = 3;
        m_turn = 0; m_shooter = 0; m_winner = 0; m_over = 0;
    endfunction

    function automatic logic [7:0] mk(int turn, int sw, int tgt, bit bad);
        logic [7:0] w;
        w = {tgt[0], sw[2:0], turn[2:0], 1'b0};
        w[0] = (^w) ^ bad;
        return w;
    endfunction

    function automatic logic [7:0] predict(logic [7:0] w);
        int t, s, g;
        logic [2:0] st;
        logic [7:0] res;
        if (m_over) return 8'hE0;
        if (^w) return 8'h80;
        t = int'(w[3:1]); s = int'(w[6:4]); g = int'(w[7]);
        if (t != m_turn) return 8'hA0;
        if (g >= 2 || g == m_shooter) return 8'hC0;
        if (m_gt[g*8+s]) begin
            m_gt[g*8+s] = 1'b0;
            m_lives[g] = m_lives[g] - 1;
            st = (m_lives[g] == 0) ? 3'b010 : 3'b001;
        end else st = 3'b000;
        res = {st, 5'(m_lives[g])};
        if (st == 3'b010) begin m_over = 1; m_winner = m_shooter; end
        m_turn = (m_turn + 1) % 8;
        m_shooter = (m_shooter + 1) % 2;
        return res;
    endfunction

    task automatic do_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        model_reset();
        sb.delete();
    endtask

    // Drive one command, then check the response byte, latency and game state.
    task automatic send(input logic [7:0] w);
        int n;
        bit was_over;
        logic [7:0] exp;
        logic [3:0] exp_lv;
        was_over = m_over;
        sb.push_back(predict(w));
        @(negedge clk);
        rx_data = w; rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin @(negedge clk); n++; end
        ncmp++;
        if (!rx_ready) begin
            nfail++; $display("FAIL accept_timeout word=%h rx_ready stuck at 0", w);
            rx_valid = 1'b0; void'(sb.pop_front()); return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1 rx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_valid && n < 20);
        exp = sb.pop_front();
        ncmp++;
        if (!tx_valid) begin
            nfail++; $display("FAIL resp_timeout word=%h no tx_valid, wanted %h", w, exp);
            return;
        end
        if (!was_over) begin
            ncmp++;
            if (n != 3) begin nfail++; $display("FAIL resp_latency word=%h got %0d want 3", w, n); end
        end
        ncmp++;
        if (tx_data !== exp) begin
            nfail++; $display("FAIL tx_data word=%h got %b want %b", w, tx_data, exp);
        end
        @(posedge clk); #1;
        exp_lv = {2'(m_lives[1]), 2'(m_lives[0])};
        ncmp++;
        if (gtable_out !== m_gt) begin
            nfail++; $display("FAIL gtable word=%h got %h want %h", w, gtable_out, m_gt);
        end
        ncmp++;
        if (lives_out !== exp_lv) begin
            nfail++; $display("FAIL lives word=%h got %h want %h", w, lives_out, exp_lv);
        end
        ncmp++;
        if (game_over !== m_over) begin
            nfail++; $display("FAIL game_over word=%h got %b want %b", w, game_over, m_over);
        end
        if (m_over) begin
            ncmp++;
            if (winner !== 1'(m_winner)) begin
                nfail++; $display("FAIL winner got %0d want %0d", winner, m_winner);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ncmp++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            nfail++; $display("FAIL reset_hs tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
        end
        ncmp++;
        if (tx_data !== 8'h00 || game_over !== 1'b0 || winner !== 1'b0) begin
            nfail++; $display("FAIL reset_out tx_data=%h game_over=%b winner=%b want 00/0/0", tx_data, game_over, winner);
        end
        ncmp++;
        if (gtable_out !== 16'hFFFF || lives_out !== 4'hF) begin
            nfail++; $display("FAIL reset_table gtable=%h lives=%h want ffff/f", gtable_out, lives_out);
        end
        @(negedge clk) rst = 1'b1;
        model_reset();
        sb.delete();
    endtask

    task automatic test_self_target();
        do_reset();
        send(8'h00);          // shooter 0 targets itself
        send(mk(0, 5, 1, 0)); // turn 0 still expected
    endtask

    task automatic test_hit_miss();
        do_reset();
        send(mk(0, 5, 1, 0));
        ncmp++;
        if (gtable_out[13] !== 1'b0) begin
            nfail++; $display("FAIL gtable_bit13 got %b want 0", gtable_out[13]);
        end
        send(mk(1, 0, 0, 0));
        send(mk(2, 5, 1, 0));
    endtask

    task automatic test_errors();
        do_reset();
        send(mk(0, 2, 1, 1));
        send(mk(0, 2, 1, 0));
        send(mk(3, 0, 0, 0));
        send(mk(1, 2, 1, 0));
        send(mk(1, 7, 0, 1));
    endtask

    task automatic test_turn_wrap();
        do_reset();
        for (int t = 0; t < 10; t++) send(mk(t % 8, 0, (t % 2 == 0) ? 1 : 0, 0));
    endtask

    task automatic test_kill();
        do_reset();
        send(mk(0, 1, 1, 0));
        send(mk(1, 1, 0, 0));
        send(mk(2, 2, 1, 0));
        send(mk(3, 2, 0, 0));
        send(mk(4, 3, 1, 0));
        send(mk(5, 4, 0, 0));
        send(mk(0, 6, 1, 1));
    endtask

    task automatic test_back_to_back();
        int a;
        do_reset();
        send(mk(0, 1, 1, 0));
        a = acc_cyc;
        send(mk(1, 1, 0, 0));
        ncmp++;
        if (acc_cyc - a != 4) begin
            nfail++; $display("FAIL throughput got %0d cycles want 4", acc_cyc - a);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] exp;
        do_reset();
        tx_ready = 1'b0;
        sb.push_back(predict(mk(0, 6, 1, 0)));
        @(negedge clk);
        rx_data = mk(0, 6, 1, 0); rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_valid && n < 20);
        exp = sb.pop_front();
        ncmp++;
        if (tx_data !== exp || !tx_valid) begin
            nfail++; $display("FAIL bp_first tx_valid=%b tx_data=%h want 1/%h", tx_valid, tx_data, exp);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ncmp++;
            if (tx_data !== exp || tx_valid !== 1'b1 || rx_ready !== 1'b0) begin
                nfail++; $display("FAIL bp_hold cyc=%0d tx_data=%h tx_valid=%b rx_ready=%b want %h/1/0",
                                  i, tx_data, tx_valid, rx_ready, exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        ncmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1) begin
            nfail++; $display("FAIL midresp_reset tx_valid=%b tx_data=%h rx_ready=%b want 0/00/1", tx_valid, tx_data, rx_ready);
        end
        ncmp++;
        if (gtable_out !== 16'hFFFF || lives_out !== 4'hF || game_over !== 1'b0) begin
            nfail++; $display("FAIL midresp_state gtable=%h lives=%h game_over=%b want ffff/f/0", gtable_out, lives_out, game_over);
        end
        tx_ready = 1'b1;
        @(negedge clk) rst = 1'b1;
        model_reset();
        sb.delete();
        send(mk(0, 6, 1, 0));
    endtask

    initial begin
        test_reset();
        test_self_target();
        test_hit_miss();
        test_errors();
        test_turn_wrap();
        test_kill();
        test_back_to_back();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
